// File: rtl/d_reg_pipe_pkg.sv
// ============================================================================
// d_reg_pkg : shared constants and sizing helper for the d_reg_pipe family
// Rev 1.0
// ============================================================================
`default_nettype none

package d_reg_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 3;

    // Width of a counter able to hold 0..depth inclusive.
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/d_reg_pipe_stage.sv
// ============================================================================
// d_reg_stage : one pipeline slot holding data and its valid bit (plus parity
//               when built wide enough); async reset, sync clear, load enable.
// Rev 1.0
// ============================================================================
`default_nettype none

module d_reg_stage #(
    parameter int           W       = 9,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] slot_q;
    logic [W-1:0] slot_d;

    always_comb begin
        slot_d = slot_q;
        if (clr_i) begin
            slot_d = RST_VAL;
        end else if (en_i) begin
            slot_d = d_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_q <= RST_VAL;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign q_o = slot_q;

endmodule

`default_nettype wire

// File: rtl/d_reg_pipe.sv
// ============================================================================
// d_reg_pipe : WIDTH-bit, DEPTH-stage delay pipe with per-stage valid, clear,
//              enable, complementary output and occupancy count.
//              Optional macro D_REG_PIPE_PARITY_EN adds q_par / par_err.
// Rev 1.0
// ============================================================================
`default_nettype none

module d_reg_pipe
    import d_reg_pkg::*;
#(
    parameter int               WIDTH   = DEF_WIDTH,
    parameter int               DEPTH   = DEF_DEPTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       clr,
    input  logic [WIDTH-1:0]           d,
    input  logic                       d_vld,
    output logic [WIDTH-1:0]           q,
    output logic [WIDTH-1:0]           qb,
`ifdef D_REG_PIPE_PARITY_EN
    output logic                       q_par,
    output logic                       par_err,
`endif
    output logic                       q_vld,
    output logic [occ_w(DEPTH)-1:0]    occ
);

`ifdef D_REG_PIPE_PARITY_EN
    localparam int PW = 1;
`else
    localparam int PW = 0;
`endif
    localparam int OW = occ_w(DEPTH);
    // Slot layout, MSB first: {data, [parity], valid}.
    localparam int SW = WIDTH + PW + 1;
    localparam logic [SW-1:0] SLOT_RST = {RST_VAL, {(PW + 1){1'b0}}};

    logic [SW-1:0]             entry;
    logic [DEPTH-1:0][SW-1:0]  stg_q;

`ifdef D_REG_PIPE_PARITY_EN
    assign entry = {d, ^d, d_vld};
`else
    assign entry = {d, d_vld};
`endif

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_stage
            logic [SW-1:0] stg_in;
            if (i == 0) begin : g_head
                assign stg_in = entry;
            end else begin : g_body
                assign stg_in = stg_q[i-1];
            end

            d_reg_stage #(
                .W       (SW),
                .RST_VAL (SLOT_RST)
            ) u_stage (
                .clk   (clk),
                .reset (reset),
                .clr_i (clr),
                .en_i  (en),
                .d_i   (stg_in),
                .q_o   (stg_q[i])
            );
        end
    endgenerate

    assign q     = stg_q[DEPTH-1][SW-1 -: WIDTH];
    assign qb    = ~q;
    assign q_vld = stg_q[DEPTH-1][0];

    // Occupancy tracks entries minus exits, so it never needs a popcount.
    logic [OW-1:0] occ_q;
    logic [OW-1:0] occ_d;

    always_comb begin
        occ_d = occ_q;
        if (clr) begin
            occ_d = '0;
        end else if (en) begin
            occ_d = occ_q + OW'(d_vld) - OW'(q_vld);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occ = occ_q;

`ifdef D_REG_PIPE_PARITY_EN
    // Check each word once, on the cycle after it lands in the last stage.
    logic out_new_q;
    logic par_err_q;

    assign q_par = stg_q[DEPTH-1][1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_new_q <= 1'b0;
            par_err_q <= 1'b0;
        end else if (clr) begin
            out_new_q <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            out_new_q <= en;
            par_err_q <= out_new_q & q_vld & ((^q) ^ q_par);
        end
    end

    assign par_err = par_err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_d_reg_pipe.sv
// ============================================================================
// tb_d_reg_pipe : scoreboard bench for d_reg_pipe against a queue-based model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_d_reg_pipe;

    localparam int         WIDTH   = 8;
    localparam int         DEPTH   = 3;
    localparam logic [7:0] RST_VAL = 8'hA5;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       clr;
    logic [7:0] d;
    logic       d_vld;
    logic [7:0] q;
    logic [7:0] qb;
    logic       q_vld;
    logic [1:0] occ;
`ifdef D_REG_PIPE_PARITY_EN
    logic       q_par;
    logic       par_err;
`endif

    d_reg_pipe #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .RST_VAL (RST_VAL)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .clr     (clr),
        .d       (d),
        .d_vld   (d_vld),
        .q       (q),
        .qb      (qb),
`ifdef D_REG_PIPE_PARITY_EN
        .q_par   (q_par),
        .par_err (par_err),
`endif
        .q_vld   (q_vld),
        .occ     (occ)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] q;
        logic       v;
        logic [1:0] occ;
        logic       par;
    } exp_t;

    exp_t expq[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    bit   mon_en = 1'b1;

    // Model: a fixed-length queue, index 0 = newest word, back = output.
    logic [7:0] m_d[$];
    bit         m_v[$];
    bit         m_p[$];

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void m_flush();
        m_d = {};
        m_v = {};
        m_p = {};
        for (int i = 0; i < DEPTH; i++) begin
            m_d.push_back(RST_VAL);
            m_v.push_back(1'b0);
            m_p.push_back(1'b0);
        end
    endfunction

    function automatic void m_edge();
        if (reset || clr) begin
            m_flush();
        end else if (en) begin
            m_d.push_front(d);
            m_v.push_front(d_vld);
            m_p.push_front(^d);
            void'(m_d.pop_back());
            void'(m_v.pop_back());
            void'(m_p.pop_back());
        end
    endfunction

    function automatic exp_t m_expect();
        exp_t e;
        int   cnt = 0;
        foreach (m_v[i]) cnt += int'(m_v[i]);
        e.q   = m_d[DEPTH-1];
        e.v   = m_v[DEPTH-1];
        e.occ = 2'(cnt);
        e.par = m_p[DEPTH-1];
        return e;
    endfunction

    task automatic step(input bit e, input bit c, input logic [7:0] dd, input bit v);
        en    = e;
        clr   = c;
        d     = dd;
        d_vld = v;
        @(posedge clk);
        m_edge();
        if (mon_en) expq.push_back(m_expect());
        @(negedge clk);
    endtask

    // Reset asserted between edges must show on the outputs before any edge.
    task automatic async_reset();
        #2 reset = 1'b1;
        #1;
        check("async_q", q, RST_VAL);
        check("async_qb", qb, 8'h5A);
        check("async_qvld", q_vld, 0);
        check("async_occ", occ, 0);
        step(1'b1, 1'b0, 8'($urandom), 1'b1);
        reset = 1'b0;
    endtask

    exp_t       mon_e;
    logic [7:0] mon_qb;

    always @(posedge clk) begin
        #1;
        if (expq.size() > 0) begin
            mon_e  = expq.pop_front();
            mon_qb = ~mon_e.q;
            check("q", q, mon_e.q);
            check("qb", qb, mon_qb);
            check("q_vld", q_vld, mon_e.v);
            check("occ", occ, mon_e.occ);
`ifdef D_REG_PIPE_PARITY_EN
            check("q_par", q_par, mon_e.par);
            check("par_err", par_err, 0);
`endif
        end
    end

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        clr   = 1'b0;
        d     = '0;
        d_vld = 1'b0;
        m_flush();
        @(negedge clk);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        reset = 1'b0;

        // Load something, then reset mid-cycle.
        step(1'b1, 1'b0, 8'h3C, 1'b1);
        step(1'b1, 1'b0, 8'hC3, 1'b1);
        async_reset();

        // Latency and fill: 11,22,33 then continue.
        step(1'b1, 1'b0, 8'h11, 1'b1);
        step(1'b1, 1'b0, 8'h22, 1'b1);
        step(1'b1, 1'b0, 8'h33, 1'b1);
        check("lat_q", q, 8'h11);
        check("lat_occ", occ, 3);
        step(1'b1, 1'b0, 8'h44, 1'b1);
        check("lat_q2", q, 8'h22);

        // Hold while full with changing d.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'($urandom), 1'b1);
        check("hold_q", q, 8'h22);
        check("hold_occ", occ, 3);
        step(1'b1, 1'b0, 8'h55, 1'b1);
        check("resume_q", q, 8'h33);

        // Bubbles: valid pattern 1,0,1 after a clear.
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h01, 1'b1);
        step(1'b1, 1'b0, 8'h02, 1'b0);
        step(1'b1, 1'b0, 8'h03, 1'b1);
        check("bub_occ", occ, 2);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, 1'b0);

        // Clear beats enable on a full pipe.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h70 + i), 1'b1);
        step(1'b1, 1'b1, 8'hEE, 1'b1);
        check("clr_q", q, RST_VAL);
        check("clr_occ", occ, 0);

        // Randomised traffic with rare clears and async resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                async_reset();
            end else begin
                step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                     8'($urandom), 1'($urandom));
            end
        end

`ifdef D_REG_PIPE_PARITY_EN
        step(1'b0, 1'b1, 8'h00, 1'b0);
        mon_en = 1'b0;
        step(1'b1, 1'b0, 8'h07, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        check("par_q", q, 8'h07);
        check("par_qpar", q_par, 1);
        step(1'b1, 1'b0, 8'h07, 1'b1);
        force dut.stg_q[0] = 10'b0000_0110_1_1;
        step(1'b1, 1'b0, 8'h00, 1'b0);
        release dut.stg_q[0];
        step(1'b1, 1'b0, 8'h00, 1'b0);
        check("perr_q", q, 8'h06);
        check("perr_vld", q_vld, 1);
        check("perr_pre", par_err, 0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        check("perr_set", par_err, 1);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        check("perr_clr", par_err, 0);
`endif

        @(negedge clk);
        check("drain", expq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
